// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling, framing-error detection
// and optional even parity when UART_RX_PARITY_EN is defined.
module uart_rx #(
    parameter int CLOCK_FREQUENCY = 25125000,
    parameter int BAUD_RATE       = 9600
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       serial_rx,
    output logic [7:0] rx_data_out,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       rx_frame_error,
    output logic       rx_parity_error
);
    localparam int CLOCKS_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int TW = $clog2(CLOCKS_PER_BIT + 1);
    localparam logic [TW-1:0] T_HALF = TW'(CLOCKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] T_FULL = TW'(CLOCKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3,
        S_BREAK  = 3'd4
`ifdef UART_RX_PARITY_EN
        , S_PARITY = 3'd5
`endif
    } state_t;

    state_t        state_q, state_d;
    logic          sync1_q, sync2_q;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          par_bad_q, par_bad_d;
    logic          perr_q, perr_d;
    logic          line;
    logic          tick;

    assign line = sync2_q;
    assign tick = (timer_q == T_FULL);

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        perr_d    = 1'b0;
        par_bad_d = par_bad_q;
        case (state_q)
            S_IDLE: begin
                timer_d   = '0;
                idx_d     = '0;
                par_bad_d = 1'b0;
                if (!line) state_d = S_START;
            end
            S_START: begin
                // Half-bit probe rejects short low glitches before committing to a frame.
                if (timer_q == T_HALF) begin
                    timer_d = '0;
                    state_d = line ? S_IDLE : S_DATA;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_DATA: begin
                if (tick) begin
                    timer_d        = '0;
                    shift_d[idx_q] = line;
                    if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    timer_d   = '0;
                    par_bad_d = line ^ (^shift_q);
                    state_d   = S_STOP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (tick) begin
                    timer_d = '0;
                    if (!line) begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end else if (par_bad_q) begin
                        perr_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        valid_d = 1'b1;
                        data_d  = shift_q;
                        state_d = S_IDLE;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_BREAK: begin
                if (line) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            state_q   <= S_IDLE;
            timer_q   <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            par_bad_q <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            sync1_q   <= serial_rx;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            timer_q   <= timer_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            par_bad_q <= par_bad_d;
            perr_q    <= perr_d;
        end
    end

    assign rx_data_out    = data_q;
    assign rx_valid       = valid_q;
    assign rx_frame_error = ferr_q;
    assign rx_busy        = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
    assign rx_parity_error = perr_q;
`else
    assign rx_parity_error = 1'b0;
`endif

endmodule
